// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode front end: function codes, instruction
// field positions, control states and the default hazard-window depth.
package pipe_pkg;

  localparam int HAZ_DEPTH_DEF  = 3;
  localparam int IMEM_DEPTH_DEF = 256;

  localparam int INSTR_W = 24;
  localparam int REG_W   = 4;
  localparam int FUNC_W  = 3;
  localparam int ADDR_W  = 8;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 3'b000;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 3'b001;
  localparam logic [FUNC_W-1:0] FUNC_DIV  = 3'b010;
  localparam logic [FUNC_W-1:0] FUNC_MUL  = 3'b011;
  localparam logic [FUNC_W-1:0] FUNC_RSH  = 3'b100;
  localparam logic [FUNC_W-1:0] FUNC_LSH  = 3'b101;
  localparam logic [FUNC_W-1:0] FUNC_NOP  = 3'b110;
  localparam logic [FUNC_W-1:0] FUNC_HALT = 3'b111;

  localparam int FUNC_MSB = 23;
  localparam int FUNC_LSB = 21;
  localparam int RD_MSB   = 20;
  localparam int RD_LSB   = 17;
  localparam int RS1_MSB  = 16;
  localparam int RS1_LSB  = 13;
  localparam int RS2_MSB  = 12;
  localparam int RS2_LSB  = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Shifts read only rs2; arithmetic ops read both sources.
  function automatic logic uses_rs1(input logic [FUNC_W-1:0] f);
    case (f)
      FUNC_ADD, FUNC_SUB, FUNC_DIV, FUNC_MUL: uses_rs1 = 1'b1;
      default:                                uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [FUNC_W-1:0] f);
    case (f)
      FUNC_ADD, FUNC_SUB, FUNC_DIV, FUNC_MUL, FUNC_RSH, FUNC_LSH: uses_rs2 = 1'b1;
      default:                                                    uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_window.sv
// RAW hazard window: a {valid, rd} history of the last HAZ_DEPTH issue slots and
// the compare against the sources of the instruction currently being fetched.
module pipe_hazard_window
  import pipe_pkg::*;
#(
  parameter int HAZ_DEPTH = HAZ_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_rd,
  input  logic             rs1_en,
  input  logic [REG_W-1:0] rs1,
  input  logic             rs2_en,
  input  logic [REG_W-1:0] rs2,
  output logic             stall
);

  logic [HAZ_DEPTH-1:0] valid_r;
  logic [REG_W-1:0]     rd_r [HAZ_DEPTH];
  logic                 stall_s;

  // Advance the window by one issue slot every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        rd_r[i]    <= {REG_W{1'b0}};
      end
    end else begin
      valid_r[0] <= in_valid;
      rd_r[0]    <= in_rd;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        rd_r[i]    <= rd_r[i-1];
      end
    end
  end

  // Stall while any in-flight destination matches a live source
  always_comb begin
    stall_s = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      stall_s = stall_s | (valid_r[i] & ((rs1_en & (rd_r[i] == rs1)) |
                                         (rs2_en & (rd_r[i] == rs2))));
    end
  end

  assign stall = stall_s;

endmodule

// File: rtl/pipe_fetch_decode.sv
// Fetch/decode front end: instruction memory, PC sequencing and field split.
// The RAW interlock is built only when PIPE_FETCH_HAZARD_EN is defined.
module pipe_fetch_decode
  import pipe_pkg::*;
#(
  parameter  int HAZ_DEPTH  = HAZ_DEPTH_DEF,
  parameter  int IMEM_DEPTH = IMEM_DEPTH_DEF,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [FUNC_W-1:0]  func,
  output logic [ADDR_W-1:0]  addr,
  output logic               out_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  logic [INSTR_W-1:0] imem_r [IMEM_DEPTH];

  state_t             state_r, state_n;
  logic [PC_W-1:0]    pc_r, pc_n;
  logic [REG_W-1:0]   rs1_r, rs1_n, rs2_r, rs2_n, rd_r, rd_n;
  logic [FUNC_W-1:0]  func_r, func_n;
  logic [ADDR_W-1:0]  addr_r, addr_n;
  logic               valid_r, valid_n, halted_r, halted_n;

  logic [INSTR_W-1:0] fetch_s;
  logic [FUNC_W-1:0]  f_func_s;
  logic [REG_W-1:0]   f_rd_s, f_rs1_s, f_rs2_s;
  logic [ADDR_W-1:0]  f_addr_s;
  logic               stall_s;
  logic               rsvd_unused_s;

  // Instruction memory write port; the read below sees the pre-write word
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_r[imem_waddr] <= imem_wdata;
    end
  end

  assign fetch_s       = imem_r[pc_r];
  assign f_func_s      = fetch_s[FUNC_MSB:FUNC_LSB];
  assign f_rd_s        = fetch_s[RD_MSB:RD_LSB];
  assign f_rs1_s       = fetch_s[RS1_MSB:RS1_LSB];
  assign f_rs2_s       = fetch_s[RS2_MSB:RS2_LSB];
  assign f_addr_s      = fetch_s[ADDR_MSB:ADDR_LSB];
  assign rsvd_unused_s = fetch_s[0];

`ifdef PIPE_FETCH_HAZARD_EN
  pipe_hazard_window #(
    .HAZ_DEPTH(HAZ_DEPTH)
  ) u_hazard_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(valid_n),
    .in_rd   (rd_n),
    .rs1_en  (uses_rs1(f_func_s)),
    .rs1     (f_rs1_s),
    .rs2_en  (uses_rs2(f_func_s)),
    .rs2     (f_rs2_s),
    .stall   (stall_s)
  );
`else
  // Without the interlock software pads dependent instructions with NOPs
  localparam int haz_depth_unused = HAZ_DEPTH;
  assign stall_s = 1'b0;
`endif

  // Next-state, PC and issue/bubble selection
  always_comb begin
    state_n  = state_r;
    pc_n     = pc_r;
    rs1_n    = rs1_r;
    rs2_n    = rs2_r;
    rd_n     = rd_r;
    addr_n   = addr_r;
    func_n   = FUNC_NOP;
    valid_n  = 1'b0;
    halted_n = halted_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          pc_n    = {PC_W{1'b0}};
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (f_func_s == FUNC_HALT) begin
          state_n  = ST_HALTED;
          halted_n = 1'b1;
        end else if (stall_s) begin
          pc_n = pc_r;
        end else begin
          rs1_n   = f_rs1_s;
          rs2_n   = f_rs2_s;
          rd_n    = f_rd_s;
          addr_n  = f_addr_s;
          func_n  = f_func_s;
          valid_n = (f_func_s != FUNC_NOP);
          pc_n    = pc_r + PC_W'(1);
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_n  = ST_RUN;
          pc_n     = {PC_W{1'b0}};
          halted_n = 1'b0;
        end else begin
          state_n = ST_HALTED;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= {PC_W{1'b0}};
      rs1_r    <= {REG_W{1'b0}};
      rs2_r    <= {REG_W{1'b0}};
      rd_r     <= {REG_W{1'b0}};
      func_r   <= FUNC_NOP;
      addr_r   <= {ADDR_W{1'b0}};
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      pc_r     <= pc_n;
      rs1_r    <= rs1_n;
      rs2_r    <= rs2_n;
      rd_r     <= rd_n;
      func_r   <= func_n;
      addr_r   <= addr_n;
      valid_r  <= valid_n;
      halted_r <= halted_n;
    end
  end

  assign rs1       = rs1_r;
  assign rs2       = rs2_r;
  assign rd        = rd_r;
  assign func      = func_r;
  assign addr      = addr_r;
  assign out_valid = valid_r;
  assign pc        = pc_r;
  assign halted    = halted_r;

endmodule
